uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
UART receiver for the UART/ALU/register-file system, the receive counterpart of the UART transmit path. It oversamples the serial line, detects start bits, deserialises DATA_WIDTH bits LSB-first, and checks optional parity and the stop bit. It delivers each good byte on a registered output with a one-cycle valid pulse. Sits in the UART clock domain and feeds the system controller through the existing data synchroniser.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
clk  input  1  receiver clock (prescale x baud rate)
reset  input  1  asynchronous, active-high reset
rx_in  input  1  serial line, idle high; already synchronised to clk upstream
prescale_in  input  6  oversampling ratio; legal values 8, 16, 32
par_en_in  input  1  1 = frame carries a parity bit
par_typ_in  input  1  0 = even parity, 1 = odd parity
data_out  output  DATA_WIDTH  last correctly received word
data_valid_out  output  1  one-cycle pulse when data_out is updated
parity_error_out  output  1  one-cycle pulse at end of a frame with a parity mismatch
stop_error_out  output  1  one-cycle pulse at end of a frame whose stop bit sampled 0
busy_out  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state IDLE, counters 0, shift register 0. data_out = 0, all pulses = 0, busy_out = 0. No partial frame is ever reported.
- Edge counter edge_cnt runs 0..P-1 per bit, where P is the latched prescale. bit_cnt counts data bits 0..DATA_WIDTH-1.
- The prescale, par_en and par_typ values are latched in the cycle a start is detected. Changes mid-frame are ignored until the next frame.
- Only P = 8, 16 and 32 are supported. Behaviour for other values is unspecified, but the FSM must always return to IDLE.
- Sampling: rx_in is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of these three samples and is used at edge_cnt = P-1 (end of bit).
- States:
  - IDLE: when rx_in == 0, move to START. That cycle is edge_cnt = 0 of the start bit.
  - START: at end of bit, a sampled value of 1 is a glitch; return to IDLE with no output and no error. A value of 0 moves to DATA with bit_cnt = 0.
  - DATA: at each end of bit, shift the sampled bit in LSB-first. After bit DATA_WIDTH-1, move to PARITY if par_en, else to STOP.
  - PARITY: expected parity is the XOR of the data bits for even parity, or its inverse for odd. A mismatch sets an internal parity-error flag.
  - STOP: at end of bit, sampled 0 means stop error. Then move to IDLE.
- End of frame: outputs are registered and take effect on the cycle after the last stop-bit edge, i.e. cycle N*P counted from the detect cycle (cycle 0).
  - N = 1 + DATA_WIDTH + par_en + 1.
  - With no errors: data_out is loaded and data_valid_out pulses high for 1 cycle.
  - With any error: data_out holds its previous value, data_valid_out stays 0, and the relevant error pulse(s) fire. Both error pulses may fire together.
- Back-to-back frames: a start detected in the very first IDLE cycle after STOP is accepted. There is no dead time beyond that one IDLE cycle.
- busy_out: registered. It rises the cycle after start detection and falls the cycle after the FSM returns to IDLE.
- Error flags are cleared at every start detection.

Test Plan:
1. P=8, par_en=0, send 0xA5 -> data_out=0xA5, data_valid_out pulses exactly once at cycle 80 after the detect cycle, no error pulses, busy_out low afterwards.
2. P=16, even parity, send 0x3C with parity bit 0 -> valid at cycle 176, data_out=0x3C. Resend 0x3C with parity bit 1 -> parity_error_out pulses, no valid pulse, data_out stays 0x3C.
3. P=8, send 0x5A with stop bit 0 -> stop_error_out pulses, data_valid_out stays 0. Next correctly framed 0x12 is received normally.
4. P=16, hold rx_in low for 3 cycles only -> FSM returns to IDLE after 16 cycles, with no valid or error pulses.
5. P=16, 0xF0 with one of the three mid-bit samples inverted on every bit -> majority vote recovers 0xF0, valid pulses. Separately, assert reset mid-DATA -> all outputs 0 immediately, and the next frame is received correctly.
6. P=32, odd parity, back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 352 cycles apart, data_out=0x00 then 0xFF, no errors.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// UART receiver: oversamples rx_in, detects a start bit, shifts in DATA_WIDTH
// data bits LSB-first, checks optional parity and the stop bit, then reports
// the frame on registered outputs on the cycle after the last stop-bit edge.
//
// Ports
//   clk              receiver clock (prescale x baud)
//   reset            asynchronous, active-high reset
//   rx_in            serial line, idle high, already synchronised to clk
//   prescale_in      oversampling ratio (8, 16 or 32), latched at start detect
//   par_en_in        1 = frame carries a parity bit, latched at start detect
//   par_typ_in       0 = even, 1 = odd parity, latched at start detect
//   data_out         last correctly received word
//   data_valid_out   one-cycle pulse when data_out is updated
//   parity_error_out one-cycle pulse at end of a frame with parity mismatch
//   stop_error_out   one-cycle pulse at end of a frame whose stop bit was 0
//   busy_out         high while the FSM is not IDLE
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [5:0]            prescale_in,
  input  logic                  par_en_in,
  input  logic                  par_typ_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  parity_error_out,
  output logic                  stop_error_out,
  output logic                  busy_out
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [5:0]            r_edge_cnt;
  logic [5:0]            r_pre;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [2:0]            r_samp;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_perr;

  logic       w_start_det;
  logic       w_bit_end;
  logic [5:0] w_half;
  logic       w_maj;
  logic       w_frame_done;
  logic       w_good;
  logic       w_busy_nxt;

  assign w_start_det = (r_state == S_IDLE) && !rx_in;
  // The 6-bit counter wraps through every value, so the end-of-bit compare is
  // always reached even for an unsupported prescale and the FSM cannot stick.
  assign w_bit_end   = (r_edge_cnt == (r_pre - 6'd1));
  assign w_half      = {1'b0, r_pre[5:1]};
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                       (r_samp[1] & r_samp[2]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!rx_in) w_state_nxt = S_START;
      S_START:  if (w_bit_end) w_state_nxt = w_maj ? S_IDLE : S_DATA;
      S_DATA:   if (w_bit_end && (r_bit_cnt == LAST_BIT))
                  w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_bit_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_frame_done = (r_state == S_STOP) && w_bit_end;
    w_good       = w_frame_done && !r_perr && w_maj;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // Bit timing, sampling and deserialisation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_cnt <= '0;
      r_pre      <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
    end else if (w_start_det) begin
      // The detect cycle counts as edge 0 of the start bit.
      r_edge_cnt <= 6'd1;
      r_pre      <= prescale_in;
      r_par_en   <= par_en_in;
      r_par_typ  <= par_typ_in;
      r_bit_cnt  <= '0;
      r_samp     <= '0;
      r_perr     <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_edge_cnt <= w_bit_end ? 6'd0 : (r_edge_cnt + 6'd1);
      if (r_edge_cnt == (w_half - 6'd1)) r_samp[0] <= rx_in;
      if (r_edge_cnt == w_half)          r_samp[1] <= rx_in;
      if (r_edge_cnt == (w_half + 6'd1)) r_samp[2] <= rx_in;
      if (w_bit_end) begin
        if (r_state == S_DATA) begin
          r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
        if ((r_state == S_PARITY) && (w_maj != ((^r_shift) ^ r_par_typ))) begin
          r_perr <= 1'b1;
        end
      end
    end else begin
      r_edge_cnt <= '0;
    end
  end

  // Registered frame outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out         <= '0;
      data_valid_out   <= 1'b0;
      parity_error_out <= 1'b0;
      stop_error_out   <= 1'b0;
      busy_out         <= 1'b0;
    end else begin
      data_valid_out   <= w_good;
      parity_error_out <= w_frame_done && r_perr;
      stop_error_out   <= w_frame_done && !w_maj;
      busy_out         <= w_busy_nxt;
      if (w_good) data_out <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
// Drives whole UART frames (directed and randomised) and compares every output
// pulse against a frame-level reference model: a frame of N = 1+8+par_en+1
// bits at P cycles per bit produces its result at cycle N*P after the start.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_in = 1'b1;
  logic [5:0]    prescale_in = 6'd8;
  logic          par_en_in = 1'b0;
  logic          par_typ_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic          parity_error_out;
  logic          stop_error_out;
  logic          busy_out;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_in            (rx_in),
    .prescale_in      (prescale_in),
    .par_en_in        (par_en_in),
    .par_typ_in       (par_typ_in),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .parity_error_out (parity_error_out),
    .stop_error_out   (stop_error_out),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    bit       v;
    bit       pe;
    bit       se;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Record every output pulse with the cycle it was seen in.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (data_valid_out || parity_error_out || stop_error_out)) begin
      e.cyc = cyc;
      e.v   = data_valid_out;
      e.pe  = parity_error_out;
      e.se  = stop_error_out;
      e.d   = data_out;
      obs_q.push_back(e);
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] rand_pre();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Sends one frame starting in the current cycle. abort_at >= 0 asserts reset
  // at that cycle offset and abandons the frame (no result expected).
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit pbit, input bit bad_stop, input bit noise,
                            input int abort_at);
    int   nb;
    logic fbits[0:11];
    int   noff[0:11];
    int   start;
    ev_t  e;
    bit   exp_pbit;
    bit   par_err;
    nb = 10 + (pe ? 1 : 0);
    fbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[1+i] = d[i];
    if (pe) fbits[9] = pbit;
    fbits[nb-1] = !bad_stop;
    for (int i = 0; i < 12; i++)
      noff[i] = (noise && i >= 1 && i <= 8) ? (p/2 - 1 + $urandom_range(0, 2)) : -1;
    prescale_in = 6'(p);
    par_en_in   = pe;
    par_typ_in  = pt;
    start = cyc;
    for (int c = 0; c < nb*p; c++) begin
      if (c == abort_at) begin
        rx_in = 1'b1;
        reset = 1'b1;
        #1;
        check_val("rst_async_outs",
                  {data_out, data_valid_out, parity_error_out, stop_error_out, busy_out}, 0);
        model_data = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      rx_in = fbits[c/p] ^ ((c % p) == noff[c/p]);
      if (c == 1) check_val("busy_rise", busy_out, 1);
      if (c == p + 1) begin
        prescale_in = rand_pre();
        par_en_in   = 1'($urandom);
        par_typ_in  = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
    exp_pbit = 1'($countones(d) % 2) ^ pt;
    par_err  = pe && (pbit != exp_pbit);
    e.cyc = start + nb*p;
    e.pe  = par_err;
    e.se  = bad_stop;
    e.v   = !par_err && !bad_stop;
    if (e.v) model_data = d;
    e.d = model_data;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] rd;
    int         rp;
    bit         rpe;
    bit         rpt;
    bit         rpb;
    int         nmin;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs",
              {data_out, data_valid_out, parity_error_out, stop_error_out, busy_out}, 0);
    reset = 1'b0;
    idle(3);

    // P=8, no parity, 0xA5
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0, -1);
    idle(4);
    check_val("busy_idle_1", busy_out, 0);

    // P=16 even parity: correct then wrong parity bit
    send_frame(8'h3C, 16, 1, 0, 0, 0, 0, -1);
    idle(2);
    send_frame(8'h3C, 16, 1, 0, 1, 0, 0, -1);
    idle(2);

    // P=8 stop error, then a good frame
    send_frame(8'h5A, 8, 0, 0, 0, 1, 0, -1);
    idle(2);
    send_frame(8'h12, 8, 0, 0, 0, 0, 0, -1);
    idle(3);

    // P=16 glitch: line low for 3 cycles only
    prescale_in = 6'd16;
    par_en_in   = 1'b0;
    rx_in       = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
    idle(7);
    check_val("glitch_busy_mid", busy_out, 1);
    idle(8);
    check_val("glitch_busy_end", busy_out, 0);

    // P=16 majority vote with one corrupted sample per data bit
    send_frame(8'hF0, 16, 0, 0, 0, 0, 1, -1);
    idle(3);

    // Reset in the middle of DATA, then a normal frame
    send_frame(8'hC3, 16, 0, 0, 0, 0, 0, 16*4 + 5);
    idle(3);
    check_val("post_rst_data", data_out, 0);
    check_val("post_rst_busy", busy_out, 0);
    send_frame(8'h6B, 16, 0, 0, 0, 0, 0, -1);
    idle(2);

    // P=32 odd parity, back-to-back 0x00 then 0xFF
    send_frame(8'h00, 32, 1, 1, 1, 0, 0, -1);
    send_frame(8'hFF, 32, 1, 1, 1, 0, 0, -1);
    idle(3);

    // Randomised frames
    for (int k = 0; k < 24; k++) begin
      rd  = 8'($urandom);
      rp  = int'(rand_pre());
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rpb = (1'($countones(rd) % 2) ^ rpt) ^ ($urandom_range(0, 4) == 0);
      send_frame(rd, rp, rpe, rpt, rpb, $urandom_range(0, 7) == 0,
                 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
    end

    idle(6);
    check_val("final_data", data_out, {24'h0, model_data});
    check_val("final_busy", busy_out, 0);
    check_val("ev_count", obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check_val($sformatf("ev%0d_cyc", i), obs_q[i].cyc, exp_q[i].cyc);
      check_val($sformatf("ev%0d_flags", i), {obs_q[i].v, obs_q[i].pe, obs_q[i].se},
                {exp_q[i].v, exp_q[i].pe, exp_q[i].se});
      check_val($sformatf("ev%0d_data", i), obs_q[i].d, exp_q[i].d);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
